// File: rtl/cell_stream_packer_if.sv
// Handshake bundle for the cell packer: pixel beats in,
// packed cells out to the processor, results back out.
interface cell_stream_packer_if #(
    parameter int PIXEL_W      = 24,
    parameter int IN_W         = 32,
    parameter int CELL_PIXELS  = 9,
    parameter int NUM_OPERANDS = 2,
    parameter int OPCODE_W     = 4
);
    localparam int CELL_W = NUM_OPERANDS * CELL_PIXELS * PIXEL_W;

    logic                         pix_valid;
    logic                         pix_ready;
    logic [NUM_OPERANDS*IN_W-1:0] pix_data;
    logic [OPCODE_W-1:0]          opcode_in;

    logic                         cell_valid;
    logic                         cell_ready;
    logic [CELL_W-1:0]            cell_data;
    logic [OPCODE_W-1:0]          cell_opcode;
    logic [PIXEL_W-1:0]           proc_pixel;

    logic                         res_valid;
    logic                         res_ready;
    logic [PIXEL_W-1:0]           res_pixel;

    modport master (
        output pix_valid, pix_data, opcode_in,
        output cell_ready, proc_pixel, res_ready,
        input  pix_ready, cell_valid, cell_data,
        input  cell_opcode, res_valid, res_pixel
    );

    modport slave (
        input  pix_valid, pix_data, opcode_in,
        input  cell_ready, proc_pixel, res_ready,
        output pix_ready, cell_valid, cell_data,
        output cell_opcode, res_valid, res_pixel
    );
endinterface

// File: rtl/cell_stream_packer.sv
// Packs operand pixel beats into 3x3 cells, issues one cell at a
// time to the processor and returns its result after a fixed latency.
module cell_stream_packer #(
    parameter int PIXEL_W        = 24,
    parameter int IN_W           = 32,
    parameter int CELL_PIXELS    = 9,
    parameter int NUM_OPERANDS   = 2,
    parameter int OPCODE_W       = 4,
    parameter int RESULT_LATENCY = 4,
    parameter int TOTAL_CELLS    = 0,
    parameter int CNT_W          = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 restart,
    input  logic                 flush,
    cell_stream_packer_if.slave  io,
    output logic [CNT_W-1:0]     cells_done,
    output logic                 done,
    output logic                 busy
);
    localparam int OP_W   = CELL_PIXELS * PIXEL_W;
    localparam int CELL_W = NUM_OPERANDS * OP_W;
    localparam int BC_W   = (CELL_PIXELS > 1) ? $clog2(CELL_PIXELS) : 1;
    localparam int LAT_W  = $clog2(RESULT_LATENCY + 1);

    typedef enum logic [2:0] {
        S_FILL,
        S_ISSUE,
        S_WAIT,
        S_RESULT,
        S_DONE
    } state_t;

    state_t              state;
    logic [BC_W-1:0]     beat_cnt;
    logic [LAT_W-1:0]    lat_cnt;
    logic [CELL_W-1:0]   cell_data_q;
    logic [OPCODE_W-1:0] cell_opcode_q;
    logic [PIXEL_W-1:0]  res_pixel_q;
    logic                cell_valid_q;
    logic                res_valid_q;
    logic [CNT_W-1:0]    cnt_base;
    logic [CNT_W-1:0]    cnt_next;
    logic                unused_pix;

    assign io.pix_ready   = (state == S_FILL) && !flush;
    assign io.cell_valid  = cell_valid_q;
    assign io.cell_data   = cell_data_q;
    assign io.cell_opcode = cell_opcode_q;
    assign io.res_valid   = res_valid_q;
    assign io.res_pixel   = res_pixel_q;

    assign busy = (state != S_FILL) || (beat_cnt != '0);

    // A restart during the result handshake makes that cell count from zero.
    assign cnt_base = restart ? '0 : cells_done;
    assign cnt_next = cnt_base + CNT_W'(1);

    assign unused_pix = ^io.pix_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_FILL;
            beat_cnt      <= '0;
            lat_cnt       <= '0;
            cell_data_q   <= '0;
            cell_opcode_q <= '0;
            res_pixel_q   <= '0;
            cell_valid_q  <= 1'b0;
            res_valid_q   <= 1'b0;
            cells_done    <= '0;
            done          <= 1'b0;
        end else begin
            if (restart && state != S_DONE)
                cells_done <= '0;

            case (state)
                S_FILL: begin
                    if (flush) begin
                        beat_cnt    <= '0;
                        cell_data_q <= '0;
                    end else if (io.pix_valid) begin
                        for (int k = 0; k < NUM_OPERANDS; k++)
                            for (int i = 0; i < CELL_PIXELS; i++)
                                if (beat_cnt == BC_W'(i))
                                    cell_data_q[k*OP_W + i*PIXEL_W +: PIXEL_W]
                                        <= io.pix_data[k*IN_W +: PIXEL_W];
                        if (beat_cnt == '0)
                            cell_opcode_q <= io.opcode_in;
                        if (beat_cnt == BC_W'(CELL_PIXELS - 1)) begin
                            beat_cnt     <= '0;
                            cell_valid_q <= 1'b1;
                            state        <= S_ISSUE;
                        end else begin
                            beat_cnt <= beat_cnt + BC_W'(1);
                        end
                    end
                end

                S_ISSUE: begin
                    if (io.cell_ready) begin
                        cell_valid_q <= 1'b0;
                        lat_cnt      <= LAT_W'(RESULT_LATENCY - 1);
                        state        <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (lat_cnt == '0) begin
                        res_pixel_q <= io.proc_pixel;
                        res_valid_q <= 1'b1;
                        state       <= S_RESULT;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end

                S_RESULT: begin
                    if (io.res_ready) begin
                        res_valid_q <= 1'b0;
                        cells_done  <= cnt_next;
                        if (TOTAL_CELLS != 0 &&
                            cnt_next == CNT_W'(TOTAL_CELLS)) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            state <= S_FILL;
                        end
                    end
                end

                S_DONE: begin
                    if (restart) begin
                        done       <= 1'b0;
                        cells_done <= '0;
                        state      <= S_FILL;
                    end
                end

                default: state <= S_FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_cell_stream_packer.sv
// Directed bench for cell_stream_packer with a cell/result scoreboard.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_cell_stream_packer;
    localparam int PW = 24;
    localparam int IW = 32;
    localparam int CP = 9;
    localparam int NO = 2;
    localparam int OW = 4;
    localparam int RL = 4;
    localparam int TC = 2;
    localparam int CW = 32;
    localparam int DW = NO * CP * PW;

    logic          clk = 1'b0;
    logic          rst;
    logic          restart;
    logic          flush;
    logic [CW-1:0] cells_done;
    logic          done;
    logic          busy;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] cell_q[$];
    logic [PW-1:0] res_q[$];
    logic [DW-1:0] exp_cell;
    logic [PW-1:0] exp_res;

    cell_stream_packer_if #(
        .PIXEL_W(PW), .IN_W(IW), .CELL_PIXELS(CP),
        .NUM_OPERANDS(NO), .OPCODE_W(OW)
    ) bus ();

    cell_stream_packer #(
        .PIXEL_W(PW), .IN_W(IW), .CELL_PIXELS(CP),
        .NUM_OPERANDS(NO), .OPCODE_W(OW),
        .RESULT_LATENCY(RL), .TOTAL_CELLS(TC), .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .restart(restart),
        .flush(flush),
        .io(bus.slave),
        .cells_done(cells_done),
        .done(done),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [511:0] obs,
                         input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Drive one full cell; operand words carry junk in the upper byte.
    task automatic send_cell(input logic [IW-1:0] a0,
                             input logic [IW-1:0] b0,
                             input logic [OW-1:0] opc);
        logic [DW-1:0] e;
        logic [IW-1:0] a;
        logic [IW-1:0] b;
        e = '0;
        for (int i = 0; i < CP; i++) begin
            a = a0 + IW'(i);
            b = b0;
            e[i*PW +: PW] = a[PW-1:0];
            e[CP*PW + i*PW +: PW] = b[PW-1:0];
            bus.pix_valid = 1'b1;
            bus.pix_data  = {b, a};
            bus.opcode_in = (i == 0) ? opc : ~opc;
            #1;
            check("beat_ready", bus.pix_ready, 1'b1);
            check("valid_early", bus.cell_valid, 1'b0);
            cyc();
        end
        bus.pix_valid = 1'b0;
        bus.pix_data  = '0;
        cell_q.push_back(e);
    endtask

    task automatic wait_res();
        int n;
        n = 0;
        while (!bus.res_valid && n < 20) begin
            cyc();
            n++;
        end
        check("res_timeout", n < 20, 1'b1);
    endtask

    initial begin
        rst            = 1'b1;
        restart        = 1'b0;
        flush          = 1'b0;
        bus.pix_valid  = 1'b0;
        bus.pix_data   = '0;
        bus.opcode_in  = '0;
        bus.cell_ready = 1'b0;
        bus.proc_pixel = '0;
        bus.res_ready  = 1'b0;
        repeat (2) cyc();

        check("rst_cell_valid", bus.cell_valid, 1'b0);
        check("rst_res_valid", bus.res_valid, 1'b0);
        check("rst_cell_data", bus.cell_data, '0);
        check("rst_cell_opcode", bus.cell_opcode, '0);
        check("rst_res_pixel", bus.res_pixel, '0);
        check("rst_cells_done", cells_done, '0);
        check("rst_done", done, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        cyc();

        // Cell 1: upper byte masked, processor back-pressure
        send_cell(32'hFF000000, 32'h00ABCDEF, 4'h5);
        exp_cell = cell_q.pop_front();
        check("c1_valid", bus.cell_valid, 1'b1);
        check("c1_data", bus.cell_data, exp_cell);
        check("c1_opcode", bus.cell_opcode, 4'h5);
        check("c1_pix_ready", bus.pix_ready, 1'b0);
        check("c1_busy", busy, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("c1_hold_valid", bus.cell_valid, 1'b1);
            check("c1_hold_data", bus.cell_data, exp_cell);
        end

        bus.cell_ready = 1'b1;
        cyc();
        bus.cell_ready = 1'b0;
        check("c1_issued", bus.cell_valid, 1'b0);
        // Only the value on the 4th edge after the handshake may be captured
        for (int k = 1; k <= RL; k++) begin
            bus.proc_pixel = (k == RL) ? 24'h123456 : PW'(k * 24'h111111);
            if (k == RL)
                res_q.push_back(24'h123456);
            cyc();
            check("c1_lat_valid", bus.res_valid, k == RL);
        end
        exp_res = res_q.pop_front();
        check("c1_res", bus.res_pixel, exp_res);
        for (int i = 0; i < 3; i++) begin
            bus.proc_pixel = 24'h654321 + PW'(i);
            cyc();
            check("c1_res_hold", bus.res_pixel, exp_res);
            check("c1_res_vhold", bus.res_valid, 1'b1);
            check("c1_cnt_hold", cells_done, '0);
        end
        bus.res_ready = 1'b1;
        cyc();
        bus.res_ready = 1'b0;
        check("c1_cnt", cells_done, 32'd1);
        check("c1_res_clr", bus.res_valid, 1'b0);
        check("c1_done", done, 1'b0);
        check("c1_idle", busy, 1'b0);

        // Partial cell of junk, then flush with a beat offered
        for (int i = 0; i < 5; i++) begin
            bus.pix_valid = 1'b1;
            bus.pix_data  = {32'h77777777, 32'h00DEAD00 + IW'(i)};
            cyc();
        end
        check("fl_busy_pre", busy, 1'b1);
        flush = 1'b1;
        bus.pix_data = {32'h55555555, 32'h00BEEF00};
        #1;
        check("fl_ready", bus.pix_ready, 1'b0);
        cyc();
        flush = 1'b0;
        bus.pix_valid = 1'b0;
        check("fl_busy", busy, 1'b0);
        check("fl_data", bus.cell_data, '0);

        // Cell 2: processor always ready, reaches TOTAL_CELLS
        bus.cell_ready = 1'b1;
        send_cell(32'h00100000, 32'hAA0F0F0F, 4'h3);
        check("c2_valid", bus.cell_valid, 1'b1);
        check("c2_data", bus.cell_data, cell_q.pop_front());
        check("c2_opcode", bus.cell_opcode, 4'h3);
        bus.proc_pixel = 24'hABCDEF;
        res_q.push_back(24'hABCDEF);
        cyc();
        bus.cell_ready = 1'b0;
        check("c2_issued", bus.cell_valid, 1'b0);
        wait_res();
        check("c2_res", bus.res_pixel, res_q.pop_front());
        bus.res_ready = 1'b1;
        cyc();
        bus.res_ready = 1'b0;
        check("c2_cnt", cells_done, 32'd2);
        check("c2_done", done, 1'b1);
        check("c2_res_clr", bus.res_valid, 1'b0);
        bus.pix_valid = 1'b1;
        #1;
        check("dn_ready", bus.pix_ready, 1'b0);
        cyc();
        bus.pix_valid = 1'b0;
        check("dn_held", done, 1'b1);
        check("dn_cell_valid", bus.cell_valid, 1'b0);

        restart = 1'b1;
        cyc();
        restart = 1'b0;
        check("rs_done", done, 1'b0);
        check("rs_cnt", cells_done, '0);
        check("rs_ready", bus.pix_ready, 1'b1);
        check("rs_busy", busy, 1'b0);

        // Cell 3: async reset while waiting on the processor
        bus.cell_ready = 1'b1;
        send_cell(32'h12300040, 32'h00C0FFEE, 4'h9);
        void'(cell_q.pop_front());
        cyc();
        bus.cell_ready = 1'b0;
        cyc();
        check("c3_in_wait", busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_cell_data", bus.cell_data, '0);
        check("ar_cell_opcode", bus.cell_opcode, '0);
        check("ar_res_valid", bus.res_valid, 1'b0);
        check("ar_busy", busy, 1'b0);
        cyc();
        rst = 1'b0;
        cyc();

        // Cell 4: normal operation after reset
        bus.cell_ready = 1'b1;
        send_cell(32'h0F00F000, 32'h11223344, 4'hC);
        check("c4_data", bus.cell_data, cell_q.pop_front());
        check("c4_opcode", bus.cell_opcode, 4'hC);
        bus.proc_pixel = 24'h0A0B0C;
        res_q.push_back(24'h0A0B0C);
        cyc();
        bus.cell_ready = 1'b0;
        wait_res();
        check("c4_res", bus.res_pixel, res_q.pop_front());
        bus.res_ready = 1'b1;
        cyc();
        bus.res_ready = 1'b0;
        check("c4_cnt", cells_done, 32'd1);
        check("c4_done", done, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
